// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable synchronous FIFO: read-mode encodings,
// reset threshold defaults, and the threshold validation rule.
package fifo_pkg;

   localparam int FWFT_STD  = 0;
   localparam int FWFT_FALL = 1;

   localparam int AE_DEFAULT = 2;
   localparam int AF_MARGIN  = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   // A threshold pair is usable only if both almost flags can ever assert
   // and the almost-empty band sits strictly below the almost-full band.
   function automatic logic thr_valid(input logic [31:0] ae,
                                      input logic [31:0] af,
                                      input logic [31:0] depth);
      return (ae >= 32'd1) && (ae < af) && (af <= depth - 32'd1);
   endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// Dual-port register array: one synchronous write port, one asynchronous read port.
module fifo_dp_ram #(
   parameter int DEPTH  = 8,
   parameter int WIDTH  = 10,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with registered fill level and flags, programmable almost
// thresholds, standard or fall-through read, and overflow/underflow reporting.
module fifo_sync_prog
   import fifo_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int FIFO_WORD_SIZE = 10,
   parameter int FIFO_PTR_SIZE  = clog2(FIFO_DEPTH),
   parameter int FWFT           = FWFT_STD,
   parameter int AE_RESET       = AE_DEFAULT,
   parameter int AF_RESET       = FIFO_DEPTH - AF_MARGIN
) (
   input  logic                      clk,
   input  logic                      reset_L,
   input  logic [FIFO_WORD_SIZE-1:0] data_in,
   input  logic                      wr_en,
   input  logic                      rd_en,
   input  logic                      init,
   input  logic [FIFO_PTR_SIZE:0]    almost_empty_threshold_input,
   input  logic [FIFO_PTR_SIZE:0]    almost_full_threshold_input,
   input  logic                      err_clr,
   output logic [FIFO_WORD_SIZE-1:0] data_out,
   output logic                      rd_valid,
   output logic [FIFO_PTR_SIZE:0]    fill_level,
   output logic                      empty_flag,
   output logic                      full_flag,
   output logic                      almost_empty_flag,
   output logic                      almost_full_flag,
   output logic                      overflow_err,
   output logic                      underflow_err,
   output logic                      error_flag,
   output logic                      cfg_error
);

   localparam int LW = FIFO_PTR_SIZE + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

   logic [LW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [LW-1:0] ae_thr_q, ae_thr_d;
   logic [LW-1:0] af_thr_q, af_thr_d;
   logic          empty_q, empty_d;
   logic          full_q, full_d;
   logic          aempty_q, aempty_d;
   logic          afull_q, afull_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          err_q, err_d;
   logic          cfg_err_q, cfg_err_d;

   logic          ptr_empty, ptr_full;
   logic          pop_ok, push_ok, thr_ok;
   logic [FIFO_WORD_SIZE-1:0] ram_rdata;

   // The extra pointer bit separates "same slot, empty" from "same slot, full".
   assign ptr_empty = (wr_ptr_q == rd_ptr_q);
   assign ptr_full  = (wr_ptr_q[FIFO_PTR_SIZE-1:0] == rd_ptr_q[FIFO_PTR_SIZE-1:0]) &&
                      (wr_ptr_q[FIFO_PTR_SIZE] != rd_ptr_q[FIFO_PTR_SIZE]);

   assign pop_ok  = rd_en & ~ptr_empty;
   assign push_ok = wr_en & (~ptr_full | pop_ok);

   assign thr_ok = thr_valid(32'(almost_empty_threshold_input),
                             32'(almost_full_threshold_input),
                             32'(FIFO_DEPTH));

   always_comb begin
      wr_ptr_d  = wr_ptr_q + LW'(push_ok);
      rd_ptr_d  = rd_ptr_q + LW'(pop_ok);
      level_d   = level_q + LW'(push_ok) - LW'(pop_ok);
      ae_thr_d  = ae_thr_q;
      af_thr_d  = af_thr_q;
      ovf_d     = wr_en & ~push_ok;
      udf_d     = rd_en & ~pop_ok;
      err_d     = (err_q & ~err_clr) | ovf_d | udf_d;
      cfg_err_d = (cfg_err_q & ~err_clr) | (init & ~thr_ok);

      if (init && thr_ok) begin
         ae_thr_d = almost_empty_threshold_input;
         af_thr_d = almost_full_threshold_input;
      end

      // Flags follow the next level but the currently active thresholds, so a
      // threshold load takes effect on the flags one cycle after it lands.
      empty_d  = (level_d == '0);
      full_d   = (level_d == DEPTH_L);
      aempty_d = (level_d != '0) && (level_d <= ae_thr_q);
      afull_d  = (level_d >= af_thr_q) && (level_d != DEPTH_L);
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         ae_thr_q  <= LW'(AE_RESET);
         af_thr_q  <= LW'(AF_RESET);
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         aempty_q  <= 1'b0;
         afull_q   <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         err_q     <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         ae_thr_q  <= ae_thr_d;
         af_thr_q  <= af_thr_d;
         empty_q   <= empty_d;
         full_q    <= full_d;
         aempty_q  <= aempty_d;
         afull_q   <= afull_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
         err_q     <= err_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   fifo_dp_ram #(
      .DEPTH  (FIFO_DEPTH),
      .WIDTH  (FIFO_WORD_SIZE),
      .ADDR_W (FIFO_PTR_SIZE)
   ) u_ram (
      .clk     (clk),
      .we_i    (push_ok),
      .waddr_i (wr_ptr_q[FIFO_PTR_SIZE-1:0]),
      .wdata_i (data_in),
      .raddr_i (rd_ptr_q[FIFO_PTR_SIZE-1:0]),
      .rdata_o (ram_rdata)
   );

   if (FWFT == FWFT_FALL) begin : g_fwft
      // Head word is presented combinationally; forced to zero while empty so
      // the output is defined out of reset.
      assign rd_valid = ~empty_q;
      assign data_out = empty_q ? '0 : ram_rdata;
   end else begin : g_std
      logic [FIFO_WORD_SIZE-1:0] dout_q, dout_d;
      logic                      rdv_q, rdv_d;

      always_comb begin
         dout_d = dout_q;
         rdv_d  = pop_ok;
         if (pop_ok) dout_d = ram_rdata;
      end

      always_ff @(posedge clk or negedge reset_L) begin
         if (!reset_L) begin
            dout_q <= '0;
            rdv_q  <= 1'b0;
         end else begin
            dout_q <= dout_d;
            rdv_q  <= rdv_d;
         end
      end

      assign rd_valid = rdv_q;
      assign data_out = dout_q;
   end

   assign fill_level        = level_q;
   assign empty_flag        = empty_q;
   assign full_flag         = full_q;
   assign almost_empty_flag = aempty_q;
   assign almost_full_flag  = afull_q;
   assign overflow_err      = ovf_q;
   assign underflow_err     = udf_q;
   assign error_flag        = err_q;
   assign cfg_error         = cfg_err_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Three FIFO configurations driven by shared stimulus and checked against a
// list-based reference model; popped words are matched through a scoreboard queue.
`timescale 1ns/1ps
module tb_fifo_sync_prog;

   typedef struct {
      int          inst;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_L = 1'b0;
   logic [31:0] din = '0;
   logic        wr_en = 1'b0, rd_en = 1'b0, init = 1'b0, err_clr = 1'b0;
   logic [3:0]  ae_in8 = '0, af_in8 = '0;
   logic [4:0]  ae_in16 = '0, af_in16 = '0;

   logic [9:0]  d0, d1;
   logic [31:0] d2;
   logic [3:0]  lvl0, lvl1;
   logic [4:0]  lvl2;
   logic        rv[3], ef[3], ff[3], aef[3], aff[3], ovf[3], udf[3], erf[3], cfe[3];
   logic [31:0] dout[3];
   logic [4:0]  lvl[3];

   assign dout[0] = {22'd0, d0};
   assign dout[1] = {22'd0, d1};
   assign dout[2] = d2;
   assign lvl[0]  = {1'b0, lvl0};
   assign lvl[1]  = {1'b0, lvl1};
   assign lvl[2]  = lvl2;

   always #5 clk = ~clk;

   fifo_sync_prog #(.FIFO_DEPTH(8), .FIFO_WORD_SIZE(10), .FWFT(0)) u_std8 (
      .clk(clk), .reset_L(reset_L), .data_in(din[9:0]), .wr_en(wr_en), .rd_en(rd_en),
      .init(init), .almost_empty_threshold_input(ae_in8), .almost_full_threshold_input(af_in8),
      .err_clr(err_clr), .data_out(d0), .rd_valid(rv[0]), .fill_level(lvl0),
      .empty_flag(ef[0]), .full_flag(ff[0]), .almost_empty_flag(aef[0]), .almost_full_flag(aff[0]),
      .overflow_err(ovf[0]), .underflow_err(udf[0]), .error_flag(erf[0]), .cfg_error(cfe[0]));

   fifo_sync_prog #(.FIFO_DEPTH(8), .FIFO_WORD_SIZE(10), .FWFT(1)) u_fwft8 (
      .clk(clk), .reset_L(reset_L), .data_in(din[9:0]), .wr_en(wr_en), .rd_en(rd_en),
      .init(init), .almost_empty_threshold_input(ae_in8), .almost_full_threshold_input(af_in8),
      .err_clr(err_clr), .data_out(d1), .rd_valid(rv[1]), .fill_level(lvl1),
      .empty_flag(ef[1]), .full_flag(ff[1]), .almost_empty_flag(aef[1]), .almost_full_flag(aff[1]),
      .overflow_err(ovf[1]), .underflow_err(udf[1]), .error_flag(erf[1]), .cfg_error(cfe[1]));

   fifo_sync_prog #(.FIFO_DEPTH(16), .FIFO_WORD_SIZE(32), .FWFT(0)) u_std16 (
      .clk(clk), .reset_L(reset_L), .data_in(din), .wr_en(wr_en), .rd_en(rd_en),
      .init(init), .almost_empty_threshold_input(ae_in16), .almost_full_threshold_input(af_in16),
      .err_clr(err_clr), .data_out(d2), .rd_valid(rv[2]), .fill_level(lvl2),
      .empty_flag(ef[2]), .full_flag(ff[2]), .almost_empty_flag(aef[2]), .almost_full_flag(aff[2]),
      .overflow_err(ovf[2]), .underflow_err(udf[2]), .error_flag(erf[2]), .cfg_error(cfe[2]));

   // Reference model: each FIFO is an ordered list, element 0 is the oldest word.
   int          depth[3] = '{8, 8, 16};
   int          fwft[3]  = '{0, 1, 0};
   logic [31:0] wmask[3] = '{32'h3FF, 32'h3FF, 32'hFFFF_FFFF};
   logic [31:0] mdata[3][16];
   int          mcnt[3], m_ae[3], m_af[3];
   bit          m_rv[3], m_ovf[3], m_udf[3], m_err[3], m_cfg[3], m_aef[3], m_aff[3];
   exp_t        expq[$];

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, inst, act, exp, $time);
      end
   endtask

   task automatic chkb(input string nm, input int inst, input logic act, input logic exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s dut%0d: got %b expected %b at %0t", nm, inst, act, exp, $time);
      end
   endtask

   task automatic step(input int i);
      int   a, f;
      bit   pop, push, ok;
      exp_t e;
      pop  = rd_en && (mcnt[i] != 0);
      push = wr_en && ((mcnt[i] != depth[i]) || pop);
      if (pop) begin
         e.inst = i;
         e.data = mdata[i][0];
         for (int k = 0; k < 15; k++) mdata[i][k] = mdata[i][k+1];
         mcnt[i]--;
         if (fwft[i] == 0) expq.push_back(e);
      end
      if (push) begin
         mdata[i][mcnt[i]] = din & wmask[i];
         mcnt[i]++;
      end
      m_rv[i]  = pop;
      m_ovf[i] = wr_en && !push;
      m_udf[i] = rd_en && !pop;
      m_err[i] = (m_err[i] && !err_clr) || m_ovf[i] || m_udf[i];
      m_aef[i] = (mcnt[i] >= 1) && (mcnt[i] <= m_ae[i]);
      m_aff[i] = (mcnt[i] >= m_af[i]) && (mcnt[i] < depth[i]);
      a  = (i == 2) ? int'(ae_in16) : int'(ae_in8);
      f  = (i == 2) ? int'(af_in16) : int'(af_in8);
      ok = (a >= 1) && (a < f) && (f <= depth[i] - 1);
      if (init && ok) begin
         m_ae[i] = a;
         m_af[i] = f;
      end
      m_cfg[i] = (m_cfg[i] && !err_clr) || (init && !ok);
   endtask

   always @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         for (int i = 0; i < 3; i++) begin
            mcnt[i] = 0; m_ae[i] = 2; m_af[i] = depth[i] - 2;
            m_rv[i] = 0; m_ovf[i] = 0; m_udf[i] = 0; m_err[i] = 0;
            m_cfg[i] = 0; m_aef[i] = 0; m_aff[i] = 0;
         end
         expq.delete();
      end else begin
         for (int i = 0; i < 3; i++) step(i);
      end
   end

   // Monitor: compares every DUT output against the model away from the rising edge.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         chk ("fill_level", i, 32'(lvl[i]), mcnt[i]);
         chkb("empty_flag", i, ef[i], mcnt[i] == 0);
         chkb("full_flag", i, ff[i], mcnt[i] == depth[i]);
         chkb("almost_empty", i, aef[i], m_aef[i]);
         chkb("almost_full", i, aff[i], m_aff[i]);
         chkb("overflow_err", i, ovf[i], m_ovf[i]);
         chkb("underflow_err", i, udf[i], m_udf[i]);
         chkb("error_flag", i, erf[i], m_err[i]);
         chkb("cfg_error", i, cfe[i], m_cfg[i]);
         if (fwft[i] == 0) begin
            chkb("rd_valid", i, rv[i], m_rv[i]);
            if (rv[i]) begin
               if (expq.size() == 0) begin
                  chkb("rd_valid_unexpected", i, rv[i], 1'b0);
               end else begin
                  e = expq.pop_front();
                  chk("sb_instance", i, e.inst, i);
                  chk("data_out", i, dout[i], e.data);
               end
            end
         end else begin
            chkb("rd_valid", i, rv[i], mcnt[i] != 0);
            if (mcnt[i] != 0) chk("data_out_head", i, dout[i], mdata[i][0]);
         end
      end
   end

   task automatic cyc(input bit w, input bit r, input logic [31:0] d = 0,
                      input bit ini = 0, input int ae = 0, input int af = 0, input bit clr = 0);
      wr_en = w; rd_en = r; din = d; init = ini; err_clr = clr;
      ae_in8 = 4'(ae); af_in8 = 4'(af); ae_in16 = 5'(ae); af_in16 = 5'(af);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      reset_L = 1'b1;
      cyc(0, 0);

      // Fill and drain at depth 8, then at depth 16.
      for (int k = 1; k <= 8; k++) cyc(1, 0, 32'(k));
      for (int k = 1; k <= 8; k++) cyc(0, 1);
      cyc(0, 0);
      for (int k = 1; k <= 16; k++) cyc(1, 0, 32'h1000_0000 + 32'(k));
      for (int k = 1; k <= 16; k++) cyc(0, 1);
      cyc(0, 0);

      // Full FIFO with simultaneous push/pop, then overflow and error clear.
      for (int k = 1; k <= 16; k++) cyc(1, 0, 32'h0200_0000 + 32'(k));
      for (int k = 0; k < 5; k++) cyc(1, 1, 32'h0300_0000 + 32'(k));
      cyc(1, 0, 32'h0000_0BAD);
      cyc(0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 16; k++) cyc(0, 1);

      // Empty FIFO: lone read, then read together with write.
      cyc(0, 1);
      cyc(0, 0);
      cyc(1, 1, 32'h0000_0155);
      cyc(0, 0);
      cyc(0, 1);

      // Threshold programming at level 4, rejected and boundary loads.
      for (int k = 0; k < 4; k++) cyc(1, 0, 32'h40 + 32'(k));
      cyc(0, 0, 0, 1, 3, 5);
      cyc(0, 0);
      cyc(1, 0, 32'h44);
      cyc(0, 0);
      cyc(0, 0, 0, 1, 5, 3);
      cyc(0, 0);
      cyc(0, 0, 0, 1, 1, 7);
      cyc(0, 0);
      cyc(0, 0, 0, 1, 1, 8);
      cyc(0, 0, 0, 1, 0, 4);
      cyc(0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 5; k++) cyc(0, 1);

      // Write into an empty FIFO with no read, then pop it.
      cyc(1, 0, 32'hAA);
      cyc(0, 0);
      cyc(0, 1);
      cyc(0, 0);

      // Asynchronous reset between edges at level 5, mid-burst.
      for (int k = 1; k <= 4; k++) cyc(1, 0, 32'h60 + 32'(k));
      wr_en = 1'b1; din = 32'h65;
      @(posedge clk);
      #2 reset_L = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chkb("async_empty", i, ef[i], 1'b1);
         chk ("async_level", i, 32'(lvl[i]), 0);
         chk ("async_dout", i, dout[i], 0);
         chkb("async_rd_valid", i, rv[i], 1'b0);
         chkb("async_error", i, erf[i], 1'b0);
      end
      wr_en = 1'b0;
      @(negedge clk);
      reset_L = 1'b1;
      for (int k = 1; k <= 3; k++) cyc(1, 0, 32'h70 + 32'(k));
      for (int k = 1; k <= 3; k++) cyc(0, 1);
      cyc(0, 0);

      // Randomised traffic with shifting read/write bias and occasional config.
      for (int n = 0; n < 900; n++) begin
         int  wb, rb;
         bit  ini, clr;
         wb  = (n < 300) ? 70 : (n < 600) ? 30 : 50;
         rb  = 100 - wb;
         ini = ($urandom_range(0, 99) < 4);
         clr = ($urandom_range(0, 99) < 5);
         cyc($urandom_range(0, 99) < wb, $urandom_range(0, 99) < rb, $urandom(),
             ini, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), clr);
      end

      for (int k = 0; k < 17; k++) cyc(0, 1);
      cyc(0, 0);
      chk("scoreboard_drained", 0, 32'(expq.size()), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
